// File: rtl/branch_resolve_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_pkg
//   Shared definitions for the branch resolution unit:
//   - 3-bit condition-code encodings used by decode and cond_eval
//   - FSM state encoding for branch_resolve
// -----------------------------------------------------------------------------
package branch_resolve_pkg;

    localparam logic [2:0] CC_NE = 3'b000;  // ~Z
    localparam logic [2:0] CC_EQ = 3'b001;  // Z
    localparam logic [2:0] CC_GT = 3'b010;  // ~Z & ~N
    localparam logic [2:0] CC_LT = 3'b011;  // N
    localparam logic [2:0] CC_GE = 3'b100;  // Z | ~N
    localparam logic [2:0] CC_LE = 3'b101;  // N | Z
    localparam logic [2:0] CC_OV = 3'b110;  // V
    localparam logic [2:0] CC_AL = 3'b111;  // always

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
//   Purely combinational branch condition evaluation.
//   Ports:
//     cond  [2:0] in   condition code (CC_* in branch_resolve_pkg)
//     NVZ   [2:0] in   flags, order {N,V,Z}
//     taken       out  1 when the branch is taken
// -----------------------------------------------------------------------------
module cond_eval
    import branch_resolve_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] NVZ,
    output logic       taken
);

    logic n, v, z;
    assign n = NVZ[2];
    assign v = NVZ[1];
    assign z = NVZ[0];

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_NE:   taken = ~z;
            CC_EQ:   taken = z;
            CC_GT:   taken = ~z & ~n;
            CC_LT:   taken = n;
            CC_GE:   taken = z | ~n;
            CC_LE:   taken = n | z;
            CC_OV:   taken = v;
            CC_AL:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//   Accepts one branch at a time from decode, captures condition/target/flags,
//   resolves one cycle later, and on a taken branch redirects the PC and holds
//   flush for FLUSH_CYC cycles in total. Keeps saturating statistics counters.
//   Ports:
//     clk, rst           clock; asynchronous active-high reset
//     br_valid/br_ready  request handshake (ready only in IDLE)
//     br_cond [2:0]      condition code
//     br_target [15:0]   branch target
//     NVZ [2:0]          bypassed flags {N,V,Z}
//     pc_sel             one-cycle pulse selecting pc_target
//     pc_target [15:0]   last captured target
//     flush              squash younger stages
//     br_total, br_taken saturating statistics counters
// -----------------------------------------------------------------------------
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_cond,
    input  logic [15:0]      br_target,
    input  logic [2:0]       NVZ,
    output logic             pc_sel,
    output logic [15:0]      pc_target,
    output logic             flush,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
);

    // Flush counter preload: FLUSH lasts FLUSH_CYC-1 cycles and exits on 0.
    localparam logic [2:0] FLUSH_LOAD = (FLUSH_CYC > 1) ? 3'(FLUSH_CYC - 2) : 3'd0;
    localparam bit         USE_FLUSH  = (FLUSH_CYC > 1);

    state_t           state_q, state_d;
    logic [2:0]       cond_q;
    logic [2:0]       nvz_q;
    logic [15:0]      target_q;
    logic [2:0]       fcnt_q;
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] taken_cnt_q;
    logic             accept;
    logic             taken;

    assign br_ready  = (state_q == ST_IDLE);
    assign accept    = br_valid & br_ready;
    assign pc_target = target_q;
    assign br_total  = total_q;
    assign br_taken  = taken_cnt_q;

    // Decision uses only captured values, so flag changes after acceptance
    // cannot alter it.
    cond_eval u_cond_eval (
        .cond  (cond_q),
        .NVZ   (nvz_q),
        .taken (taken)
    );

    always_comb begin
        state_d = state_q;
        pc_sel  = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (taken) begin
                    pc_sel  = 1'b1;
                    flush   = 1'b1;
                    state_d = USE_FLUSH ? ST_FLUSH : ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (fcnt_q == 3'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cond_q      <= 3'd0;
            nvz_q       <= 3'd0;
            target_q    <= 16'd0;
            fcnt_q      <= 3'd0;
            total_q     <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                cond_q   <= br_cond;
                nvz_q    <= NVZ;
                target_q <= br_target;
            end

            if (state_q == ST_RESOLVE && taken && USE_FLUSH) begin
                fcnt_q <= FLUSH_LOAD;
            end else if (state_q == ST_FLUSH && fcnt_q != 3'd0) begin
                fcnt_q <= fcnt_q - 3'd1;
            end

            // Counters saturate at all-ones instead of wrapping.
            if (state_q == ST_RESOLVE) begin
                if (total_q != '1) total_q <= total_q + CNT_W'(1);
                if (taken && taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter: FLUSH_CYC, default 2, total cycles flush is asserted per taken branch (legal 1..7).
REQ-002 Parameter: CNT_W, default 16, width of the statistics counters.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: br_valid  input  1  branch request from decode.
REQ-006 Port: br_ready  output  1  unit can accept a request this cycle.
REQ-007 Port: br_cond  input  3  condition code of the branch.
REQ-008 Port: br_target  input  16  branch target address.
REQ-009 Port: NVZ  input  3  current flags from the flag register, bypassed; order {N,V,Z}.
REQ-010 Port: pc_sel  output  1  select pc_target as the next PC.
REQ-011 Port: pc_target  output  16  registered target address.
REQ-012 Port: flush  output  1  squash younger pipeline stages.
REQ-013 Port: br_total  output  CNT_W  branches resolved.
REQ-014 Port: br_taken  output  CNT_W  branches taken.

Function
REQ-015 The FSM SHALL have three states: IDLE, RESOLVE, FLUSH.
REQ-016 br_ready SHALL be 1 only in IDLE; a request is accepted when br_valid and br_ready are both 1.
REQ-017 On acceptance the unit SHALL capture br_cond, br_target and NVZ in that same edge and move to RESOLVE; later NVZ changes SHALL NOT affect the decision.
REQ-018 Taken SHALL evaluate on the captured values: 000 NE: ~Z; 001 EQ: Z; 010 GT: ~Z & ~N; 011 LT: N; 100 GE: Z | ~N; 101 LE: N | Z; 110 OV: V; 111 always.
REQ-019 In RESOLVE, if taken: pc_sel=1, flush=1, pc_target=captured target, br_taken and br_total increment; the next state is FLUSH if FLUSH_CYC>1, otherwise IDLE.
REQ-020 In RESOLVE, if not taken: pc_sel=0, flush=0, br_total increments; the next state is IDLE.
REQ-021 RESOLVE SHALL last exactly one cycle, giving one-cycle latency from acceptance to decision.
REQ-022 In FLUSH, flush SHALL be 1 and pc_sel SHALL be 0; a down-counter SHALL hold FLUSH for FLUSH_CYC-1 cycles, then return to IDLE.
REQ-023 The flush counter SHALL load FLUSH_CYC-2 on entry to FLUSH and leave FLUSH when it reads 0.
REQ-024 pc_sel SHALL be a single-cycle pulse per taken branch.
REQ-025 pc_target SHALL hold its last captured value outside RESOLVE.
REQ-026 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-027 br_valid SHALL be ignored outside IDLE; the requester holds it until accepted.
REQ-028 The earliest new acceptance SHALL be the cycle after returning to IDLE (back-to-back not-taken branches: one accept every 2 cycles).

Reset
REQ-029 rst SHALL force IDLE, br_ready=1, pc_sel=0, flush=0, pc_target=0, br_total=0, br_taken=0 and flush counter=0 immediately, asynchronously.
REQ-030 Asserting rst mid-RESOLVE or mid-FLUSH SHALL abandon the branch with no counter update.
REQ-031 The first acceptance SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-032 A shared package SHALL hold the 3-bit condition-code constants and the FSM state encoding.
REQ-033 The condition evaluation SHALL be one combinational sub-module, cond_eval (inputs cond and NVZ; output taken).
REQ-034 The counters, FSM and capture registers SHALL live in branch_resolve.

Verification
REQ-035 EQ with NVZ=001 -> next cycle: pc_sel=1, flush=1, pc_target=br_target; flush stays 1 for one further cycle; br_taken=1, br_total=1.
REQ-036 GT with NVZ=100 -> not taken: pc_sel=0, flush=0, br_total=1, br_taken=0; br_ready returns after one cycle.
REQ-037 Capture check: LT accepted with NVZ=100, NVZ changes to 000 the next cycle -> branch still taken.
REQ-038 Sweep all 8 conditions x 8 NVZ values -> decisions match the REQ-018 table.
REQ-039 Preload counters near saturation (0xFFFE) and issue 3 taken branches -> both counters stop at 0xFFFF.
REQ-040 Assert rst during FLUSH -> flush=0 and br_ready=1 immediately; counters=0.
